sdram_avalon_arbiter: RTL and testbench

- Two-master arbiter between the SDRAM image writer (write-only master W) and the SDRAM-to-VGA-FIFO reader (read-only master R).
- Drives the single Avalon-MM slave port of the SDRAM controller.
- Replaces the static write-done address/enable mux.
- Reads are prioritised for VGA real-time traffic, with a fairness limit so writes are not starved.
- Tracks outstanding pipelined reads and routes read data back to R.

---
 rtl/sdram_avalon_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_avalon_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avalon_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_avalon_arbiter
//
// Two-master arbiter in front of the single Avalon-MM slave port of the SDRAM
// controller. Master W (image writer) only writes; master R (VGA FIFO filler)
// only reads. Reads win ties because the display is real-time, but a run
// counter forces a yield to a waiting writer after FAIR_LIMIT consecutive
// accepted reads, and the same limit applies to a writer run. Outstanding
// pipelined reads are counted and capped at MAX_PENDING; read data returns to
// R straight from the controller with no added latency, in every state.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width
//   MAX_PENDING  outstanding reads allowed (1..15)
//   FAIR_LIMIT   accepted transfers per run before yielding (1..255)
//
// Ports
//   iCLK, iRST                    clock, asynchronous active-high reset
//   iWR_REQ/ADDR/DATA, oWR_WAIT   write master W
//   iRD_REQ/ADDR, oRD_WAIT        read master R command side
//   oRD_DATA, oRD_DATAVALID       read master R return side
//   oS_ADDR/WRDATA/RD/WR, iS_WAIT controller command side
//   iS_RDDATA, iS_RDDATAVALID     controller return side
//   oPENDING                      current outstanding read count
//
// Optional build macro ARB_STATS_EN adds the statistics outputs
//   oSTAT_RD_CNT, oSTAT_WR_CNT, oSTAT_MAX_PEND, oSTAT_STALL_CNT.
// Without it those ports do not exist and arbitration is unchanged.
// -----------------------------------------------------------------------------
module sdram_avalon_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 4,
  parameter int FAIR_LIMIT  = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  // write master W
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_WAIT,
  // read master R
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_WAIT,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_DATAVALID,
  // SDRAM controller slave port
  output logic [ADDR_W-1:0] oS_ADDR,
  output logic [DATA_W-1:0] oS_WRDATA,
  output logic              oS_RD,
  output logic              oS_WR,
  input  logic              iS_WAIT,
  input  logic [DATA_W-1:0] iS_RDDATA,
  input  logic              iS_RDDATAVALID,
  output logic [3:0]        oPENDING
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       oSTAT_RD_CNT,
  output logic [31:0]       oSTAT_WR_CNT,
  output logic [3:0]        oSTAT_MAX_PEND,
  output logic [31:0]       oSTAT_STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2
  } state_e;

  localparam logic [3:0] MAX_P  = 4'(MAX_PENDING);
  localparam logic [7:0] FAIR_L = 8'(FAIR_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [7:0] run_q, run_d;
  // Set when the last read grant ended with its run exhausted, so the next
  // tie in IDLE goes to the writer instead of the reader.
  logic       wr_turn_q, wr_turn_d;

  logic       rd_room;
  logic       rd_accept;
  logic       wr_accept;
  logic [7:0] run_inc;

  assign rd_room   = (pending_q < MAX_P);
  assign rd_accept = oS_RD & ~iS_WAIT;
  assign wr_accept = oS_WR & ~iS_WAIT;
  // Run count after one more accept, saturating at the limit.
  assign run_inc   = (run_q == FAIR_L) ? run_q : run_q + 8'd1;

  // ---------------------------------------------------------------------------
  // Slave-side and wait outputs: combinational from the grant state and the
  // granted master's inputs, so a held request is accepted the same cycle the
  // controller drops its waitrequest.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    oS_ADDR   = '0;
    oS_WRDATA = '0;
    oS_RD     = 1'b0;
    oS_WR     = 1'b0;
    oRD_WAIT  = 1'b1;
    oWR_WAIT  = 1'b1;
    unique case (state_q)
      GNT_RD: begin
        oS_ADDR  = iRD_ADDR;
        oS_RD    = iRD_REQ & rd_room;
        // At the pending limit R must keep holding its request.
        oRD_WAIT = iS_WAIT | ~rd_room;
      end
      GNT_WR: begin
        oS_ADDR   = iWR_ADDR;
        oS_WRDATA = iWR_DATA;
        oS_WR     = iWR_REQ;
        oWR_WAIT  = iS_WAIT;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant sequencing. A grant is only left when its master has no request
  // pending, or right on an accept, so an unaccepted request never loses the
  // bus and its address/data stay valid under Avalon hold rules.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    wr_turn_d = wr_turn_q;
    unique case (state_q)
      IDLE: begin
        if (iRD_REQ && rd_room && !(iWR_REQ && wr_turn_q)) begin
          state_d = GNT_RD;
          run_d   = '0;
        end else if (iWR_REQ) begin
          state_d = GNT_WR;
          run_d   = '0;
        end
      end
      GNT_RD: begin
        if (rd_accept) run_d = run_inc;
        if (!iRD_REQ || (rd_accept && iWR_REQ && run_inc == FAIR_L)) begin
          state_d   = IDLE;
          wr_turn_d = (run_d == FAIR_L);
        end
      end
      GNT_WR: begin
        if (wr_accept) run_d = run_inc;
        if (!iWR_REQ || (wr_accept && iRD_REQ && run_inc == FAIR_L)) begin
          state_d   = IDLE;
          wr_turn_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding read count. A return with nothing outstanding (possible
  // right after a reset that dropped in-flight reads) leaves it at zero.
  always_comb begin
    pending_d = pending_q;
    if (rd_accept && !iS_RDDATAVALID) begin
      pending_d = pending_q + 4'd1;
    end else if (!rd_accept && iS_RDDATAVALID && pending_q != 4'd0) begin
      pending_d = pending_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others regardless of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      run_q     <= '0;
      wr_turn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      run_q     <= run_d;
      wr_turn_q <= wr_turn_d;
    end
  end

  assign oPENDING = pending_q;

  // Return path is a pure wire so in-flight data survives a reset or a
  // write grant.
  assign oRD_DATA      = iS_RDDATA;
  assign oRD_DATAVALID = iS_RDDATAVALID;

`ifdef ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics. Counters wrap and clear only on reset. The high-water mark
  // follows the next pending value so it agrees with oPENDING a cycle later.
  // ---------------------------------------------------------------------------
  logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;
  logic [3:0]  stat_max_q;
  logic        stall;

  assign stall = (iRD_REQ & oRD_WAIT) | (iWR_REQ & oWR_WAIT);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
      stat_max_q   <= '0;
    end else begin
      if (rd_accept) stat_rd_q <= stat_rd_q + 32'd1;
      if (wr_accept) stat_wr_q <= stat_wr_q + 32'd1;
      if (stall) stat_stall_q <= stat_stall_q + 32'd1;
      if (pending_d > stat_max_q) stat_max_q <= pending_d;
    end
  end

  assign oSTAT_RD_CNT    = stat_rd_q;
  assign oSTAT_WR_CNT    = stat_wr_q;
  assign oSTAT_MAX_PEND  = stat_max_q;
  assign oSTAT_STALL_CNT = stat_stall_q;
`endif

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for sdram_avalon_arbiter (FAIR_LIMIT=4, MAX_PENDING=4).
// A behavioural model of the grant/run/pending rules predicts every output
// each cycle; an Avalon-style master and controller model provide stimulus,
// and directed phases pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_sdram_avalon_arbiter;

  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int MAXP = 4;
  localparam int FL   = 4;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iWR_REQ = 1'b0;
  logic [AW-1:0] iWR_ADDR = '0;
  logic [DW-1:0] iWR_DATA = '0;
  logic          oWR_WAIT;
  logic          iRD_REQ = 1'b0;
  logic [AW-1:0] iRD_ADDR = '0;
  logic          oRD_WAIT;
  logic [DW-1:0] oRD_DATA;
  logic          oRD_DATAVALID;
  logic [AW-1:0] oS_ADDR;
  logic [DW-1:0] oS_WRDATA;
  logic          oS_RD;
  logic          oS_WR;
  logic          iS_WAIT = 1'b0;
  logic [DW-1:0] iS_RDDATA = '0;
  logic          iS_RDDATAVALID = 1'b0;
  logic [3:0]    oPENDING;
`ifdef ARB_STATS_EN
  logic [31:0]   st_rd, st_wr, st_stall;
  logic [3:0]    st_max;
`endif

  sdram_avalon_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP), .FAIR_LIMIT(FL)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iWR_REQ(iWR_REQ), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .oWR_WAIT(oWR_WAIT),
    .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR), .oRD_WAIT(oRD_WAIT),
    .oRD_DATA(oRD_DATA), .oRD_DATAVALID(oRD_DATAVALID),
    .oS_ADDR(oS_ADDR), .oS_WRDATA(oS_WRDATA), .oS_RD(oS_RD), .oS_WR(oS_WR),
    .iS_WAIT(iS_WAIT), .iS_RDDATA(iS_RDDATA),
    .iS_RDDATAVALID(iS_RDDATAVALID), .oPENDING(oPENDING)
`ifdef ARB_STATS_EN
    ,
    .oSTAT_RD_CNT(st_rd), .oSTAT_WR_CNT(st_wr),
    .oSTAT_MAX_PEND(st_max), .oSTAT_STALL_CNT(st_stall)
`endif
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
    end
  endtask

  // Stimulus knobs
  bit rst_cmd    = 1'b1;
  bit force_wait = 1'b0;
  bit stray_cmd  = 1'b0;
  int p_rd = 0, p_wr = 0, p_wait = 0, p_stray = 0;
  int lat  = 2;             // 0 selects a random latency per read

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          ctl_q[$];  // controller's in-flight reads
  logic [DW-1:0] r_exp[$];  // data R must see, in order
  bit            s_stray = 1'b0;

  // Behavioural model: who owns the bus, run length, outstanding reads,
  // and whether the writer is owed the next tie.
  int m_owner = 0;          // 0 none, 1 reader, 2 writer
  int m_run = 0, m_pend = 0;
  bit m_wr_turn = 1'b0;

  bit  last_rd_acc = 1'b0, last_wr_acc = 1'b0;
  int  dut_wr_acc = 0, rd_returns = 0, dut_pend_max = 0, full_wait_cycles = 0;
  byte pat_ch = "-";

  // Compare process: predicted outputs versus DUT, then advance the model.
  always @(negedge iCLK) begin
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat, rdat;
    bit e_srd, e_swr, e_rwait, e_wwait, acc_r, acc_w;
    int pend_n, run_n;
    if (iRST) begin
      m_owner = 0; m_run = 0; m_pend = 0; m_wr_turn = 1'b0;
    end
    e_addr = '0; e_wdat = '0; e_srd = 0; e_swr = 0; e_rwait = 1; e_wwait = 1;
    if (m_owner == 1) begin
      e_addr  = iRD_ADDR;
      e_srd   = iRD_REQ && (m_pend < MAXP);
      e_rwait = iS_WAIT || (m_pend == MAXP);
    end else if (m_owner == 2) begin
      e_addr  = iWR_ADDR;
      e_wdat  = iWR_DATA;
      e_swr   = iWR_REQ;
      e_wwait = iS_WAIT;
    end
    check("s_addr",   64'(oS_ADDR),       64'(e_addr));
    check("s_wrdata", 64'(oS_WRDATA),     64'(e_wdat));
    check("s_rd",     64'(oS_RD),         64'(e_srd));
    check("s_wr",     64'(oS_WR),         64'(e_swr));
    check("rd_wait",  64'(oRD_WAIT),      64'(e_rwait));
    check("wr_wait",  64'(oWR_WAIT),      64'(e_wwait));
    check("pending",  64'(oPENDING),      64'(m_pend));
    check("rd_valid", 64'(oRD_DATAVALID), 64'(iS_RDDATAVALID));
    check("rd_data",  64'(oRD_DATA),      64'(iS_RDDATA));

    acc_r = e_srd && !iS_WAIT;
    acc_w = e_swr && !iS_WAIT;
    last_rd_acc = acc_r;
    last_wr_acc = acc_w;

    // Observed bus activity for the directed literal checks.
    pat_ch = (oS_RD && !iS_WAIT) ? "R" : (oS_WR && !iS_WAIT) ? "W" : "-";
    if (oS_WR && !iS_WAIT) dut_wr_acc++;
    if (int'(oPENDING) > dut_pend_max) dut_pend_max = int'(oPENDING);
    if (oPENDING == 4'(MAXP) && oRD_WAIT) full_wait_cycles++;

    // In-order return scoreboard for R.
    if (iS_RDDATAVALID && !s_stray) begin
      if (r_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_order: got %0h expected no data (cycle %0d)", oRD_DATA, cyc);
      end else begin
        check("rd_order", 64'(oRD_DATA), 64'(r_exp.pop_front()));
        rd_returns++;
      end
    end
    if (acc_r) begin
      rdat = DW'($urandom);
      ctl_q.push_back('{cyc + ((lat > 0) ? lat : int'($urandom_range(10, 1))), rdat});
      r_exp.push_back(rdat);
    end

    if (!iRST) begin
      pend_n = m_pend + int'(acc_r) - int'(iS_RDDATAVALID);
      if (pend_n < 0) pend_n = 0;
      case (m_owner)
        0: begin
          if (iRD_REQ && m_pend < MAXP && !(iWR_REQ && m_wr_turn)) begin
            m_owner = 1; m_run = 0;
          end else if (iWR_REQ) begin
            m_owner = 2; m_run = 0;
          end
        end
        1: begin
          run_n = acc_r ? ((m_run + 1 > FL) ? FL : m_run + 1) : m_run;
          m_run = run_n;
          if (!iRD_REQ || (acc_r && iWR_REQ && run_n == FL)) begin
            m_owner = 0; m_wr_turn = (run_n == FL);
          end
        end
        default: begin
          run_n = acc_w ? ((m_run + 1 > FL) ? FL : m_run + 1) : m_run;
          m_run = run_n;
          if (!iWR_REQ || (acc_w && iRD_REQ && run_n == FL)) begin
            m_owner = 0; m_wr_turn = 1'b0;
          end
        end
      endcase
      m_pend = pend_n;
    end
  end

  // Masters hold an unaccepted request; the controller returns reads in order.
  task automatic drive();
    iRST = rst_cmd;
    if (rst_cmd) begin
      iRD_REQ = 1'b0;
      iWR_REQ = 1'b0;
    end else begin
      if (!iRD_REQ || last_rd_acc) begin
        iRD_REQ  = ($urandom_range(99) < p_rd);
        iRD_ADDR = AW'($urandom);
      end
      if (!iWR_REQ || last_wr_acc) begin
        iWR_REQ  = ($urandom_range(99) < p_wr);
        iWR_ADDR = AW'($urandom);
        iWR_DATA = DW'($urandom);
      end
    end
    iS_WAIT = force_wait || ($urandom_range(99) < p_wait);
    s_stray = 1'b0;
    if (stray_cmd) begin
      iS_RDDATAVALID = 1'b1; iS_RDDATA = 16'hBEEF; s_stray = 1'b1;
    end else if (ctl_q.size() > 0 && ctl_q[0].due <= cyc) begin
      iS_RDDATAVALID = 1'b1; iS_RDDATA = ctl_q[0].data;
      void'(ctl_q.pop_front());
    end else if (p_stray > 0 && $urandom_range(99) < p_stray) begin
      iS_RDDATAVALID = 1'b1; iS_RDDATA = DW'($urandom); s_stray = 1'b1;
    end else begin
      iS_RDDATAVALID = 1'b0; iS_RDDATA = DW'($urandom);
    end
  endtask

  // One full cycle: drive after the rising edge, return after the compare.
  task automatic cycle();
    @(posedge iCLK);
    cyc++;
    #1;
    drive();
    @(negedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    cycle();
    cycle();
    rst_cmd = 1'b0;
  endtask

  task automatic capture(input int n, output string s);
    s = "";
    for (int i = 0; i < n; i++) begin
      cycle();
      s = $sformatf("%s%c", s, pat_ch);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    int    budget;

    // Reset values
    do_reset();
    check("rst_s_rd",     64'(oS_RD),         64'd0);
    check("rst_s_wr",     64'(oS_WR),         64'd0);
    check("rst_s_addr",   64'(oS_ADDR),       64'd0);
    check("rst_s_wrdata", 64'(oS_WRDATA),     64'd0);
    check("rst_rd_wait",  64'(oRD_WAIT),      64'd1);
    check("rst_wr_wait",  64'(oWR_WAIT),      64'd1);
    check("rst_pending",  64'(oPENDING),      64'd0);
    check("rst_rd_valid", 64'(oRD_DATAVALID), 64'd0);

    // Write only: one IDLE decision cycle, then ten back-to-back writes.
    p_rd = 0; p_wr = 100; p_wait = 0; lat = 2;
    dut_wr_acc = 0;
    repeat (11) cycle();
    check("wo_accepts", 64'(dut_wr_acc), 64'd10);
    check("wo_pending", 64'(oPENDING),   64'd0);

    // Read pipeline limit with 8-cycle return latency.
    do_reset();
    p_rd = 100; p_wr = 0; lat = 8;
    rd_returns = 0; dut_pend_max = 0; full_wait_cycles = 0;
    budget = 400;
    while (rd_returns < 20 && budget > 0) begin
      cycle();
      budget--;
    end
    check("pipe_returns", 64'(rd_returns), 64'd20);
    check("pipe_pend_max", 64'(dut_pend_max), 64'd4);
    check("pipe_full_wait_seen", 64'(full_wait_cycles > 0), 64'd1);

    // Fairness: both request continuously.
    do_reset();
    p_rd = 100; p_wr = 100; lat = 2;
    capture(20, pat);
    check_str("fair_pattern", pat, "-RRRR-WWWW-RRRR-WWWW");

    // Wait hold during a write grant while R requests.
    do_reset();
    p_rd = 0; p_wr = 100; lat = 3;
    cycle();
    cycle();
    force_wait = 1'b1; p_rd = 100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_s_wr", 64'(oS_WR),    64'd1);
      check("hold_s_rd", 64'(oS_RD),    64'd0);
      check("hold_rwait", 64'(oRD_WAIT), 64'd1);
    end
    force_wait = 1'b0;
    capture(6, pat);
    check_str("hold_pattern", pat, "WWW-RR");

    // Simultaneous accept and return at pending=2, latency 2.
    do_reset();
    p_rd = 100; p_wr = 0; lat = 2;
    repeat (6) cycle();
    check("simul_pending", 64'(oPENDING), 64'd2);
    cycle();
    check("simul_pending2", 64'(oPENDING), 64'd2);

    // Stray return with nothing outstanding.
    p_rd = 0;
    repeat (15) cycle();
    check("drain_pending", 64'(oPENDING), 64'd0);
    stray_cmd = 1'b1;
    cycle();
    stray_cmd = 1'b0;
    check("stray_valid",   64'(oRD_DATAVALID), 64'd1);
    check("stray_data",    64'(oRD_DATA),      64'hBEEF);
    check("stray_pending", 64'(oPENDING),      64'd0);
    cycle();
    check("stray_pending2", 64'(oPENDING), 64'd0);

    // Reset mid-read with three reads outstanding.
    do_reset();
    p_rd = 100; p_wr = 0; lat = 8;
    repeat (4) cycle();
    force_wait = 1'b1;
    cycle();
    check("mid_pending", 64'(oPENDING), 64'd3);
    check("mid_s_rd",    64'(oS_RD),    64'd1);
    rst_cmd = 1'b1;
    cycle();
    check("mid_rst_pending", 64'(oPENDING), 64'd0);
    check("mid_rst_s_rd",    64'(oS_RD),    64'd0);
    check("mid_rst_rd_wait", 64'(oRD_WAIT), 64'd1);
    check("mid_rst_wr_wait", 64'(oWR_WAIT), 64'd1);
    check("mid_rst_s_addr",  64'(oS_ADDR),  64'd0);
`ifdef ARB_STATS_EN
    check("mid_rst_stat_rd", 64'(st_rd), 64'd0);
`endif
    rst_cmd = 1'b0; force_wait = 1'b0;
    cycle();
    cycle();
    cycle();
`ifdef ARB_STATS_EN
    check("stat_rd_after_rst", 64'(st_rd), 64'd1);
`endif
    p_rd = 0;
    repeat (20) cycle();

    // Randomized traffic with waits, variable latency, strays and resets.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      p_rd = 40 + 20 * blk; p_wr = 70 - 15 * blk; p_wait = 25; p_stray = 2; lat = 0;
      repeat (1000) cycle();
    end
    p_rd = 0; p_wr = 0; p_wait = 0; p_stray = 0;
    repeat (30) cycle();
    check("final_r_exp_empty", 64'(r_exp.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
